// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment driver. It snapshots packed BCD once per frame and
// scans the digits with active-low anodes and segments.
module bcd_display_scan #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);
  localparam int NUM_DIG = 4;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_DARK = 7'b1111111;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_slot;
  logic [15:0]   r_snap_d;
  logic [3:0]    r_snap_dp;
  logic          r_snap_lz;
  logic          r_snap_evt;

  logic          w_tick;
  logic          w_snap;
  logic [3:0]    w_cur;
  logic [3:1]    w_dig_zero;
  logic [3:1]    w_lead_zero;
  logic [3:0]    w_blank_mask;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign w_tick = (r_cnt == CNT_LAST);
  assign w_snap = w_tick && (r_slot == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_slot <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_slot <= r_slot + 2'd1;
    end
  end

  // Inputs are only looked at on the last tick of a frame, so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_d   <= '0;
      r_snap_dp  <= '0;
      r_snap_lz  <= 1'b0;
      r_snap_evt <= 1'b0;
    end else begin
      r_snap_evt <= w_snap;
      if (w_snap) begin
        r_snap_d  <= digits_in;
        r_snap_dp <= dp_in;
        r_snap_lz <= blank_lz;
      end
    end
  end

  // A digit is a leading zero when it and every more-significant digit are 0.
  // Digit 0 always shows, and non-BCD codes count as nonzero.
  genvar g;
  generate
    for (g = 1; g < NUM_DIG; g++) begin : g_lz
      assign w_dig_zero[g] = (r_snap_d[4*g +: 4] == 4'h0);
      if (g == NUM_DIG - 1) begin : g_top
        assign w_lead_zero[g] = w_dig_zero[g];
      end else begin : g_mid
        assign w_lead_zero[g] = w_dig_zero[g] && w_lead_zero[g+1];
      end
      assign w_blank_mask[g] = r_snap_lz && w_lead_zero[g];
    end
  endgenerate
  assign w_blank_mask[0] = 1'b0;

  assign w_cur = r_snap_d[{r_slot, 2'b00} +: 4];
  assign w_seg = w_blank_mask[r_slot] ? SEG_DARK : bcd_to_seg(w_cur);
  assign w_an  = ~(4'b0001 << r_slot);

  // Output stage lags slot by one cycle. frame_start lands with the first new digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= 4'b1111;
      seg         <= SEG_DARK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= w_an;
      seg         <= w_seg;
      dp          <= ~r_snap_dp[r_slot];
      frame_start <= r_snap_evt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan (REFRESH_DIV=4). Stimulus pushes the expected
// outputs for each edge into a queue, and a negedge monitor pops them and compares.
module tb_bcd_display_scan;
  localparam int R = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  bcd_display_scan #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per active edge, checked half a cycle later.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if ({an, seg, dp, frame_start} !== e) begin
        n_fail++;
        $display("FAIL out_chk #%0d: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
                 n_tests, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
      end
    end
  end

  task automatic cyc(input exp_t e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  // Pushes len edges of one displayed frame. It applies the next inputs after edge index chg.
  task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input logic [3:0] dpb, input logic fs,
                       input int chg, input int len, input logic [15:0] nd,
                       input logic [3:0] ndp, input logic nlz);
    logic [6:0] sv [4];
    exp_t e;
    int   k;
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    for (int i = 0; i < len; i++) begin
      k = i / R;
      e.an = 4'b1111;
      e.an[k] = 1'b0;
      e.seg = sv[k];
      e.dp = ~dpb[k];
      e.fs = fs && (i == 0);
      cyc(e);
      if (i == chg) begin
        digits_in = nd;
        dp_in     = ndp;
        blank_lz  = nlz;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dark;
    n_tests = 0;
    n_fail  = 0;
    dark = '{an: 4'b1111, seg: SB, dp: 1'b1, fs: 1'b0};

    rst       = 1'b1;
    digits_in = 16'($urandom);
    dp_in     = 4'($urandom);
    blank_lz  = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      cyc(dark);
      digits_in = 16'($urandom);
      dp_in     = 4'($urandom);
      blank_lz  = 1'($urandom);
    end
    rst = 1'b0;

    // Frame 0 shows the cleared snapshot. It then loads 1234 with the digit-2 point lit.
    frame(S0, S0, S0, S0, 4'b0000, 1'b0, 0, 16, 16'h1234, 4'b0100, 1'b0);
    // frame_start lands on edge 17 together with the new digit 0.
    frame(S4, S3, S2, S1, 4'b0100, 1'b1, 0, 16, 16'h0070, 4'b0000, 1'b1);
    frame(S0, S7, SB, SB, 4'b0000, 1'b1, 0, 16, 16'h0000, 4'b0000, 1'b1);
    frame(S0, SB, SB, SB, 4'b0000, 1'b1, 0, 16, 16'h1111, 4'b0000, 1'b0);
    // Inputs change mid-frame while slot 1 is scanning. The frame must not tear.
    frame(S1, S1, S1, S1, 4'b0000, 1'b1, 0, 16, 16'h1111, 4'b0000, 1'b0);
    frame(S1, S1, S1, S1, 4'b0000, 1'b1, 5, 16, 16'h9999, 4'b0000, 1'b0);
    frame(S9, S9, S9, S9, 4'b0000, 1'b1, 0, 16, 16'hF0A5, 4'b0000, 1'b1);
    frame(S5, SD, S0, SD, 4'b0000, 1'b1, 0, 16, 16'h1234, 4'b1111, 1'b0);
    // Reset pulse while slot 2 is scanning.
    frame(S4, S3, S2, S1, 4'b1111, 1'b1, -1, 9, 16'h0, 4'b0, 1'b0);
    rst = 1'b1;
    cyc(dark);
    rst = 1'b0;
    frame(S0, S0, S0, S0, 4'b0000, 1'b0, -1, 16, 16'h0, 4'b0, 1'b0);
    frame(S4, S3, S2, S1, 4'b1111, 1'b1, -1, 16, 16'h0, 4'b0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed 4-digit 7-segment display driver that sits directly downstream of the BCD counter stages. It consumes four packed BCD digits, such as four cascaded `bcd_counter` `q` outputs, and snapshots them once per frame so the display never tears. It scans one digit at a time with active-low anodes and segments. It decodes BCD to segments, blanks leading zeros on request, and shows a dash for non-BCD codes.

## Interface
- `REFRESH_DIV`, default 1000: clock cycles per digit slot; legal range ≥ 2.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: synchronous reset, active-high.
- `digits_in` in 16: packed BCD. [3:0] = digit 0 (least significant) … [15:12] = digit 3 (most significant).
- `dp_in` in 4: decimal point request per digit; bit k belongs to digit k; 1 = lit.
- `blank_lz` in 1: 1 = blank leading zeros.
- `an` out 4: anode enables, active-low; bit k selects digit k.
- `seg` out 7: segments, active-low; bit0 = a … bit6 = g.
- `dp` out 1: decimal point segment, active-low.
- `frame_start` out 1: one-cycle pulse marking that a new snapshot was taken.

## Operation
- **Prescaler `cnt`:** counts 0..REFRESH_DIV-1 and increments every cycle. When `cnt` == REFRESH_DIV-1, `cnt` returns to 0 and `tick` asserts for that cycle.
- **Slot register `slot` (0..3):** advances by 1 on each `tick`, wrapping 3→0. Scan order is 0,1,2,3,0,…
- **Snapshot:**
  - On a `tick` with `slot` == 3, `digits_in`, `dp_in` and `blank_lz` are captured into `snap_d`, `snap_dp` and `snap_lz`.
  - `frame_start` is registered high for exactly that one following cycle.
  - Inputs are ignored at every other time; changes mid-frame appear only in the next frame.
- **Decode of `snap_d` digit `slot`, active-low {g,f,e,d,c,b,a}:**
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - Codes A–F = 0111111 (g only, a dash).
- **Leading-zero blanking:**
  - When `snap_lz`=1, digit k (k = 1..3) is blanked (`seg` = 1111111) if digits k..3 of `snap_d` are all 4'h0.
  - Digit 0 is never blanked.
  - Non-BCD codes count as nonzero.
  - `an` still selects a blanked digit. `dp` still follows `snap_dp`.
- **Anodes:** `an` = all ones except bit `slot`, which is 0.
- **Reset** (any cycle `rst`=1, overriding `tick`):
  - `cnt`=0, `slot`=0, `snap_d`=16'h0000, `snap_dp`=0, `snap_lz`=0.
  - `an`=1111, `seg`=1111111, `dp`=1, `frame_start`=0.

## Timing
- All outputs are registered from `slot` and the snapshot registers, so they lag a `slot` change by one cycle.
- Reset mid-scan takes effect at the next edge. Dark outputs are held while `rst`=1.
- First edge with `rst`=0: `an`=1110, `seg`=1000000 (snapshot 0), `dp`=1.
- Each digit is displayed for exactly REFRESH_DIV cycles, so a frame lasts 4·REFRESH_DIV cycles.
- First snapshot after reset: `tick` #4, i.e. edge 4·REFRESH_DIV after reset release. `frame_start` is high on edge 4·REFRESH_DIV+1.
- The new digit-0 value appears on `seg` on the same edge as `frame_start`.
- Input change → displayed latency: at most 4·REFRESH_DIV+1 cycles, at least 1.
- There is no back-pressure and no input handshake. Sampling happens only at the snapshot edge.

## Test plan
Bench uses REFRESH_DIV=4.
- **Reset:** hold `rst`=1 for 3 cycles with random inputs → `an`=1111, `seg`=1111111, `dp`=1, `frame_start`=0 throughout. First edge after release → `an`=1110, `seg`=1000000.
- **Scan/snapshot:** `digits_in`=16'h1234, `dp_in`=4'b0100, `blank_lz`=0.
  - `frame_start` pulses at cycle 17 after release.
  - Then, 4 cycles each: `an`=1110 `seg`=0011001; `an`=1101 `seg`=0110000; `an`=1011 `seg`=0100100 with `dp`=0; `an`=0111 `seg`=1111001.
- **Leading-zero blanking:** `digits_in`=16'h0070, `blank_lz`=1.
  - Digit 3 (`an`=0111) → `seg`=1111111.
  - Digit 2 (`an`=1011) → `seg`=1111111.
  - Digit 1 → `seg`=1111000; digit 0 → `seg`=1000000.
  - With `digits_in`=16'h0000: only digit 0 lit, showing "0".
- **Tearing:** change `digits_in` from 16'h1111 to 16'h9999 while `slot`=1 → remaining digits of that frame still show 1111001. All digits show 0010000 from the next `frame_start`.
- **Invalid code:** `digits_in`=16'hF0A5 → digit 0 shows 0010010. Digits 1 and 3 show 0111111. Digit 2 shows 1000000 and is not blanked even with `blank_lz`=1.
- **Reset mid-frame:** assert `rst` for 1 cycle while `slot`=2 → next edge outputs are dark and the snapshot is cleared. The scan restarts at digit 0 showing "0". `frame_start` is next seen 4·REFRESH_DIV+1 cycles after release.
